// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// State encoding is common to the FSM and anything probing it.
package pattern_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_PARITY,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_tx_if.sv
// Start handshake plus serial stream of the pattern transmitter.
// master = requester/sink side, slave = the transmitter.
interface pattern_tx_if #(
   parameter int WIDTH = 4,
   parameter int REP_W = 4
);

   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [REP_W-1:0] reps;
   logic             ready;
   logic             x;
   logic             x_valid;
   logic             done;

   modport master (
      output start, pattern, reps,
      input  ready, x, x_valid, done
   );

   modport slave (
      input  start, pattern, reps,
      output ready, x, x_valid, done
   );

endinterface

// File: rtl/pattern_tx_shift.sv
// MSB-first shift register with a down-counting bit counter.
// load has priority over shift; last_bit marks the final bit of a frame.
module pattern_tx_shift
   import pattern_tx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             msb,
   output logic             last_bit
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load) begin
         sreg <= data;
         cnt  <= CW'(WIDTH);
      end else if (shift) begin
         sreg <= {sreg[WIDTH-2:0], 1'b0};
         cnt  <= cnt - CW'(1);
      end
   end

   assign msb      = sreg[WIDTH-1];
   assign last_bit = (cnt == CW'(1));

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first.
// Optional even-parity bit per frame with PATTERN_TX_PARITY_EN.
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int REP_W = 4,
   parameter int GAP   = 1
) (
   input  logic         clk,
   input  logic         rst,
   pattern_tx_if.slave  bus
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t           state;
   state_t           state_n;
   state_t           after_frame;
   logic [REP_W-1:0] frames;
   logic [GW-1:0]    gap_cnt;
   logic [WIDTH-1:0] pat_q;
   logic [WIDTH-1:0] load_data;
   logic             par_q;
   logic             ready_q;
   logic             xv_q;
   logic             done_q;
   logic             par_sel;
   logic             accept;
   logic             more;
   logic             frame_end;
   logic             gap_end;
   logic             load;
   logic             shift;
   logic             msb;
   logic             last_bit;

   always_comb begin
      accept    = (state == ST_IDLE) && bus.start;
      more      = (frames > REP_W'(1));
      gap_end   = (state == ST_GAP) && (gap_cnt == '0);
      shift     = (state == ST_SHIFT);
`ifdef PATTERN_TX_PARITY_EN
      frame_end = (state == ST_PARITY);
`else
      frame_end = (state == ST_SHIFT) && last_bit;
`endif
      if (!more)
         after_frame = ST_DONE;
      else if (GAP > 0)
         after_frame = ST_GAP;
      else
         after_frame = ST_SHIFT;
      // back-to-back frames reload in the cycle of the last bit
      load      = accept
               || (frame_end && more && (GAP == 0))
               || gap_end;
      load_data = accept ? bus.pattern : pat_q;

      state_n = state;
      unique case (state)
         ST_IDLE:
            if (bus.start)
               state_n = ST_SHIFT;
         ST_SHIFT:
            if (last_bit) begin
`ifdef PATTERN_TX_PARITY_EN
               state_n = ST_PARITY;
`else
               state_n = after_frame;
`endif
            end
`ifdef PATTERN_TX_PARITY_EN
         ST_PARITY:
            state_n = after_frame;
`endif
         ST_GAP:
            if (gap_cnt == '0)
               state_n = ST_SHIFT;
         ST_DONE:
            state_n = ST_IDLE;
         default:
            state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         frames  <= '0;
         gap_cnt <= '0;
         pat_q   <= WIDTH'(DEFAULT_PATTERN);
         par_q   <= 1'b0;
         ready_q <= 1'b1;
         xv_q    <= 1'b0;
         done_q  <= 1'b0;
         par_sel <= 1'b0;
      end else begin
         state   <= state_n;
         ready_q <= (state_n == ST_IDLE);
         xv_q    <= (state_n == ST_SHIFT)
                 || (state_n == ST_PARITY);
         done_q  <= (state_n == ST_DONE);
         par_sel <= (state_n == ST_PARITY);

         if (accept) begin
            frames <= (bus.reps == '0) ? REP_W'(1) : bus.reps;
            pat_q  <= bus.pattern;
            par_q  <= ^bus.pattern;
         end else if (frame_end) begin
            frames <= frames - REP_W'(1);
         end

         if ((state_n == ST_GAP) && (state != ST_GAP))
            gap_cnt <= GW'((GAP > 0) ? GAP - 1 : 0);
         else if (state == ST_GAP)
            gap_cnt <= gap_cnt - GW'(1);
      end
   end

   pattern_tx_shift #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift    (shift),
      .data     (load_data),
      .msb      (msb),
      .last_bit (last_bit)
   );

   assign bus.ready   = ready_q;
   assign bus.x_valid = xv_q;
   assign bus.done    = done_q;
   assign bus.x       = xv_q & (par_sel ? par_q : msb);

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: one instance with GAP=1, one with GAP=0.
// Expected streams are strings: '0'/'1' valid bit, '-' idle, 'D' done.
module tb_pattern_tx;

`ifdef PATTERN_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      int cyc;
      bit dn;
      bit b;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   compared;
   int   mismatched;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0;
   exp_t e1;
   logic [3:0] hist;
   int   det;

   pattern_tx_if #(.WIDTH(4), .REP_W(4)) i0 ();
   pattern_tx_if #(.WIDTH(4), .REP_W(4)) i1 ();

   pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (i0)
   );

   pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (i1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic string fr(input string b, input string p);
      return PAR ? {b, p} : b;
   endfunction

   // GAP=0 monitor, also feeds a 1011 overlapping Moore detector
   always @(negedge clk) begin
      if (!rst) begin
         if (i0.x_valid || i0.done) begin
            if (q0.size() == 0) begin
               chk("g0_extra", 1, 0);
            end else begin
               e0 = q0.pop_front();
               chk("g0_cyc", cyc, e0.cyc);
               chk("g0_kind", int'(i0.done), int'(e0.dn));
               if (!e0.dn) chk("g0_x", int'(i0.x), int'(e0.b));
            end
            if (i0.x_valid) begin
               if ({hist[2:0], i0.x} == 4'b1011) det++;
               hist = {hist[2:0], i0.x};
            end
         end else begin
            chk("g0_xidle", int'(i0.x), 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (i1.x_valid || i1.done) begin
            if (q1.size() == 0) begin
               chk("g1_extra", 1, 0);
            end else begin
               e1 = q1.pop_front();
               chk("g1_cyc", cyc, e1.cyc);
               chk("g1_kind", int'(i1.done), int'(e1.dn));
               if (!e1.dn) chk("g1_x", int'(i1.x), int'(e1.b));
            end
         end else begin
            chk("g1_xidle", int'(i1.x), 0);
         end
      end
   end

   task automatic drive(input int d, input logic s,
                        input logic [3:0] p, input logic [3:0] r);
      if (d == 0) begin
         i0.start = s; i0.pattern = p; i0.reps = r;
      end else begin
         i1.start = s; i1.pattern = p; i1.reps = r;
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? i0.ready : i1.ready;
   endfunction

   task automatic issue(input int d, input logic [3:0] p,
                        input logic [3:0] r, input string s,
                        output int c0);
      exp_t e;
      byte  ch;
      @(negedge clk);
      drive(d, 1'b1, p, r);
      chk("accept_rdy", int'(rdy(d)), 1);
      c0 = cyc;
      for (int i = 0; i < s.len(); i++) begin
         ch = s[i];
         if (ch != "-") begin
            e.cyc = c0 + i + 1;
            e.dn  = (ch == "D");
            e.b   = (ch == "1");
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      @(negedge clk);
      // scramble inputs: they must not matter after acceptance
      drive(d, 1'b0, ~p, ~r);
   endtask

   task automatic wait_done(input int d, input int c0, input int len);
      int n;
      n = 0;
      while (qsize(d) != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         chk("timeout", 0, 1);
         if (d == 0) q0.delete();
         else        q1.delete();
      end
      chk("done_cyc", cyc, c0 + len);
      chk("done_rdy", int'(rdy(d)), 0);
      @(negedge clk);
      #1;
      chk("ready_back", int'(rdy(d)), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      string sa, sb, sc, sh1, sh0, s15;
      int c0;
      compared = 0;
      mismatched = 0;
      hist = '0;
      det = 0;
      rst = 1'b1;
      drive(0, 1'b0, 4'h0, 4'h0);
      drive(1, 1'b0, 4'h0, 4'h0);

      sa  = {fr("1011", "1"), "D"};
      sb  = {fr("1011", "1"), "-", fr("1011", "1"), "-",
             fr("1011", "1"), "D"};
      sc  = {fr("1011", "1"), fr("1011", "1"), "D"};
      sh1 = {fr("0110", "0"), "-", fr("0110", "0"), "D"};
      sh0 = {fr("1000", "1"), "D"};
      s15 = "";
      for (int i = 0; i < 15; i++) s15 = {s15, fr("1011", "1")};
      s15 = {s15, "D"};

      #1;
      chk("rst_ready", int'(i1.ready), 1);
      chk("rst_x", int'(i1.x), 0);
      chk("rst_xv", int'(i1.x_valid), 0);
      chk("rst_done", int'(i1.done), 0);
      chk("rst_ready0", int'(i0.ready), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // single frame, GAP=1
      issue(1, 4'b1011, 4'd1, sa, c0);
      wait_done(1, c0, sa.len());

      // three frames separated by one idle cycle
      issue(1, 4'b1011, 4'd3, sb, c0);
      wait_done(1, c0, sb.len());

      // back-to-back frames into a 1011 detector
      @(negedge clk);
      hist = '0;
      det = 0;
      issue(0, 4'b1011, 4'd2, sc, c0);
      wait_done(0, c0, sc.len());
      chk("detections", det, 2);

      // start during a busy frame and during DONE is ignored
      issue(1, 4'b1011, 4'd1, sa, c0);
      drive(1, 1'b1, 4'b0110, 4'd5);
      while (cyc < c0 + sa.len()) begin
         @(negedge clk);
         #1;
         chk("busy_rdy", int'(i1.ready), 0);
      end
      @(negedge clk);
      drive(1, 1'b0, 4'b0110, 4'd5);
      #1;
      chk("busy_ready_back", int'(i1.ready), 1);
      chk("busy_q_empty", q1.size(), 0);
      repeat (8) @(negedge clk);
      chk("busy_still_idle", int'(i1.ready), 1);

      // reset while the second bit is on x
      issue(1, 4'b1011, 4'd3, sb, c0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_x", int'(i1.x), 0);
      chk("mid_rst_xv", int'(i1.x_valid), 0);
      chk("mid_rst_ready", int'(i1.ready), 1);
      chk("mid_rst_done", int'(i1.done), 0);
      q1.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_ready", int'(i1.ready), 1);

      // fresh start after the abort
      issue(1, 4'b1011, 4'd1, sa, c0);
      wait_done(1, c0, sa.len());

      // reps=0 sends exactly one frame
      issue(1, 4'b1011, 4'd0, sa, c0);
      wait_done(1, c0, sa.len());

      // other patterns
      issue(1, 4'b0110, 4'd2, sh1, c0);
      wait_done(1, c0, sh1.len());
      issue(0, 4'b1000, 4'd1, sh0, c0);
      wait_done(0, c0, sh0.len());

      // maximum repeat count, no wrap
      issue(0, 4'b1011, 4'd15, s15, c0);
      wait_done(0, c0, s15.len());

      repeat (3) @(negedge clk);
      chk("q0_left", q0.size(), 0);
      chk("q1_left", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
